instr_fetch: RTL and testbench

- Produces the instruction stream consumed by the main control decoder: it owns the PC, issues word reads to instruction memory over a valid/ready handshake, and holds one fetched instruction plus its PC for the decode stage.
- Applies branch redirects (Branch & Zero from the datapath) and decode-stage stalls.
- Drives a 6-bit opcode that decodes to "no-op" whenever no valid instruction is held.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM state encoding and the
// default address width used by the front end.
package cpu_pkg;

  localparam int ADDR_W = 32;

  localparam logic [5:0] R_FMT      = 6'b000000;
  localparam logic [5:0] LW         = 6'b100011;
  localparam logic [5:0] SW         = 6'b101011;
  localparam logic [5:0] BEQ        = 6'b000100;
  localparam logic [5:0] NOP_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one imem read at a time and holds the
// fetched word plus its PC until the decode stage consumes it.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int               ADDR_W     = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [5:0]       NOP_OPCODE = cpu_pkg::NOP_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_unused_tgt_lsb;

  // Wraps silently at the top of the address space.
  assign w_pc_plus4       = r_instr_pc + ADDR_W'(4);
  assign w_unused_tgt_lsb = ^branch_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= RESET_PC;
    end else begin
      case (r_state)
        REQ: begin
          if (imem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          // Responses outside WAIT (e.g. stale ones across a reset) are dropped.
          if (imem_resp_valid) begin
            r_instr       <= imem_resp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (r_instr_valid && !stall) begin
            r_pc          <= branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : w_pc_plus4;
            r_instr_valid <= 1'b0;
            r_state       <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign pc_plus4       = w_pc_plus4;
  assign opcode         = r_instr_valid ? r_instr[31:26] : NOP_OPCODE;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of sequential fetches followed by
// hand-written sequences for back-pressure, stall, branch, wrap and reset.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;

  instr_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [5:0]  opc;
    int          ticks;
  } vec_t;

  vec_t        vecs [0:2];
  logic [31:0] mem [0:31];
  int          checks = 0;
  int          errors = 0;
  int          req_cnt = 0;
  int          cnt0;
  int          n;
  bit          auto_resp = 1'b1;
  logic [31:0] last_req_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: note acceptance before the edge, drive the memory reply after it.
  task automatic tick();
    bit acc;
    acc = imem_req_valid && imem_req_ready && !reset;
    if (acc) begin
      req_cnt++;
      last_req_addr = imem_req_addr;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc && auto_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem[last_req_addr[6:2]];
    end else begin
      imem_resp_valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 + 32'(i);
    mem[0]  = 32'h0022_1820;
    mem[1]  = 32'h8C01_0004;
    mem[2]  = 32'hAC02_0008;
    mem[3]  = 32'h8C01_0004;
    mem[16] = 32'h1022_0003;
    mem[31] = 32'hAC1F_00FC;
    vecs[0] = '{32'h0, 32'h0022_1820, R_FMT, 2};
    vecs[1] = '{32'h4, 32'h8C01_0004, LW,    3};
    vecs[2] = '{32'h8, 32'hAC02_0008, SW,    3};

    tick();
    tick();
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'h3F);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    reset = 1'b0;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);

    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!instr_valid && n < 8);
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_ticks", 32'(n), 32'(vecs[i].ticks));
      chk("seq_req_addr", last_req_addr, vecs[i].addr);
      chk("seq_instr_pc", instr_pc, vecs[i].addr);
      chk("seq_instr", instr, vecs[i].word);
      chk("seq_opcode", 32'(opcode), 32'(vecs[i].opc));
      chk("seq_pc_plus4", pc_plus4, vecs[i].addr + 32'd4);
    end
    chk("seq_req_cnt", 32'(req_cnt), 32'd3);

    imem_req_ready = 1'b0;
    tick();
    cnt0 = req_cnt;
    chk("bp_valid", 32'(imem_req_valid), 32'd1);
    chk("bp_addr", imem_req_addr, 32'hC);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_addr", imem_req_addr, 32'hC);
    end
    chk("bp_no_accept", 32'(req_cnt), 32'(cnt0));
    imem_req_ready = 1'b1;
    tick();
    chk("bp_one_accept", 32'(req_cnt), 32'(cnt0 + 1));
    chk("bp_valid_drop", 32'(imem_req_valid), 32'd0);
    tick();
    chk("bp_instr", instr, 32'h8C01_0004);
    chk("bp_instr_pc", instr_pc, 32'hC);

    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h8C01_0004);
      chk("stall_opcode", 32'(opcode), 32'(LW));
      chk("stall_instr_pc", instr_pc, 32'hC);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    chk("stall_req_cnt", 32'(req_cnt), 32'(cnt0 + 1));
    stall = 1'b0;
    branch_taken = 1'b0;
    chk("stall_pc_plus4", pc_plus4, 32'h10);
    tick();
    chk("release_addr", imem_req_addr, 32'h10);
    chk("release_opcode_nop", 32'(opcode), 32'h3F);
    tick();
    tick();
    chk("hold_10_pc", instr_pc, 32'h10);

    branch_taken = 1'b1;
    branch_target = 32'h0000_0043;
    tick();
    branch_taken = 1'b0;
    chk("br_addr", imem_req_addr, 32'h40);
    tick();
    tick();
    chk("br_instr_pc", instr_pc, 32'h40);
    chk("br_opcode", 32'(opcode), 32'(BEQ));

    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_instr", instr, 32'hAC1F_00FC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    tick();
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    auto_resp = 1'b0;
    tick();
    chk("rw_in_wait", 32'(imem_req_valid), 32'd0);
    reset = 1'b1;
    tick();
    chk("rw_rst_opcode", 32'(opcode), 32'h3F);
    chk("rw_rst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    cnt0 = req_cnt;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h8C01_0004;
    tick();
    chk("rw_stale_valid", 32'(instr_valid), 32'd0);
    chk("rw_stale_opcode", 32'(opcode), 32'h3F);
    chk("rw_first_req", 32'(req_cnt), 32'(cnt0 + 1));
    chk("rw_first_addr", last_req_addr, 32'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data = mem[0];
    tick();
    chk("rw_valid", 32'(instr_valid), 32'd1);
    chk("rw_instr", instr, 32'h0022_1820);
    chk("rw_instr_pc", instr_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
